// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the single FIFO write port between a register-file
// byte source and a two-byte ALU result source. It accepts one request at a
// time, arbitrates ties round-robin, and serialises ALU results low byte
// first. It never writes while the FIFO reports full.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16   // must be 2*DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  rf_vld,
    output logic                  rf_rdy,
    input  logic [ALU_WIDTH-1:0]  alu_out,
    input  logic                  alu_vld,
    output logic                  alu_rdy,
    input  logic                  full,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  w_inc,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        SEND_RF,
        SEND_ALU_LO,
        SEND_ALU_HI
    } state_t;

    localparam logic GRANT_RF  = 1'b0;
    localparam logic GRANT_ALU = 1'b1;

    state_t                state;
    state_t                state_nxt;
    logic                  last_grant;
    logic                  grant_rf;
    logic                  grant_alu;
    logic [DATA_WIDTH-1:0] hold_hi;
    logic [DATA_WIDTH-1:0] wr_data_q;

    // Arbitration, next-state and write strobe; grants are suppressed while
    // reset is asserted so the ready outputs drop immediately with it.
    always_comb begin
        state_nxt = state;
        grant_rf  = 1'b0;
        grant_alu = 1'b0;
        w_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n) begin
                    if (rf_vld && alu_vld) begin
                        if (last_grant == GRANT_RF) grant_alu = 1'b1;
                        else                        grant_rf  = 1'b1;
                    end else if (rf_vld) begin
                        grant_rf = 1'b1;
                    end else if (alu_vld) begin
                        grant_alu = 1'b1;
                    end
                end
                if (grant_rf)  state_nxt = SEND_RF;
                if (grant_alu) state_nxt = SEND_ALU_LO;
            end
            SEND_RF: begin
                w_inc = !full;
                if (!full) state_nxt = IDLE;
            end
            SEND_ALU_LO: begin
                w_inc = !full;
                if (!full) state_nxt = SEND_ALU_HI;
            end
            SEND_ALU_HI: begin
                w_inc = !full;
                if (!full) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rf_rdy  = grant_rf;
    assign alu_rdy = grant_alu;
    assign busy    = (state != IDLE);
    assign wr_data = wr_data_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture the accepted payload and advance the output byte; wr_data_q
    // keeps the last byte presented so it holds steady through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_hi    <= '0;
            wr_data_q  <= '0;
            last_grant <= GRANT_RF;
        end else if (grant_rf) begin
            wr_data_q  <= rf_rd_data;
            last_grant <= GRANT_RF;
        end else if (grant_alu) begin
            hold_hi    <= alu_out[ALU_WIDTH-1:DATA_WIDTH];
            wr_data_q  <= alu_out[DATA_WIDTH-1:0];
            last_grant <= GRANT_ALU;
        end else if (state == SEND_ALU_LO && !full) begin
            wr_data_q  <= hold_hi;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a scoreboard queue receives the
// expected FIFO bytes when requests are driven and a monitor pops them on
// every write strobe.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rf_rd_data = '0;
    logic        rf_vld = 1'b0;
    logic        rf_rdy;
    logic [15:0] alu_out = '0;
    logic        alu_vld = 1'b0;
    logic        alu_rdy;
    logic        full;
    logic [7:0]  wr_data;
    logic        w_inc;
    logic        busy;

    logic        full_force = 1'b0;
    logic        fifo_mode = 1'b0;
    logic        fifo_full = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  fifo_mem[$];
    logic [7:0]  rd_q[$];
    int          max_occ = 0;

    logic [7:0]  exp_q[$];
    logic        model_last = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          wr_count = 0;

    assign full = fifo_mode ? fifo_full : full_force;

    fifo_wr_arbiter #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .rf_rd_data(rf_rd_data), .rf_vld(rf_vld), .rf_rdy(rf_rdy),
        .alu_out(alu_out), .alu_vld(alu_vld), .alu_rdy(alu_rdy),
        .full(full), .wr_data(wr_data), .w_inc(w_inc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Write monitor: sampled just before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (w_inc === 1'b1) begin
            wr_count++;
            total++;
            if (full !== 1'b0) begin
                bad++;
                $display("[TB] FAIL write_while_full: w_inc=%b full=%b need full=0", w_inc, full);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_write: wr_data=%h, no byte expected", wr_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (wr_data !== e) begin
                    bad++;
                    $display("[TB] FAIL wr_data: got %h need %h", wr_data, e);
                end
            end
        end
    end

    // Small 8-deep FIFO model used by the streaming scenario.
    always @(posedge clk) begin
        if (fifo_mode) begin
            if (w_inc === 1'b1) fifo_mem.push_back(wr_data);
            if (rd_en && fifo_mem.size() > 0) rd_q.push_back(fifo_mem.pop_front());
            if (fifo_mem.size() > max_occ) max_occ = fifo_mem.size();
            fifo_full <= (fifo_mem.size() >= 8);
        end else begin
            fifo_full <= 1'b0;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rf_vld = 1'b0;
        alu_vld = 1'b0;
        full_force = 1'b0;
        exp_q.delete();
        model_last = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one or two simultaneous requests and push the expected bytes in
    // round-robin order; returns on the falling edge after the last accept.
    task automatic drive_req(input logic use_rf, input logic [7:0] rb,
                             input logic use_alu, input logic [15:0] aw, input string tag);
        logic rf_pend, alu_pend, first_seen, exp_alu_first;
        int   cyc;
        exp_alu_first = use_alu && (!use_rf || model_last == 1'b0);
        if (exp_alu_first) begin
            exp_q.push_back(aw[7:0]);
            exp_q.push_back(aw[15:8]);
            if (use_rf) exp_q.push_back(rb);
            model_last = use_rf ? 1'b0 : 1'b1;
        end else begin
            if (use_rf) exp_q.push_back(rb);
            if (use_alu) begin
                exp_q.push_back(aw[7:0]);
                exp_q.push_back(aw[15:8]);
            end
            model_last = use_alu ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        rf_rd_data = rb;
        alu_out = aw;
        rf_vld = use_rf;
        alu_vld = use_alu;
        rf_pend = use_rf;
        alu_pend = use_alu;
        first_seen = 1'b0;
        cyc = 0;
        while ((rf_pend || alu_pend) && cyc < 60) begin
            #4;
            total++;
            if (rf_rdy === 1'b1 && alu_rdy === 1'b1) begin
                bad++;
                $display("[TB] FAIL %s_both_rdy: rf_rdy=%b alu_rdy=%b need at most one", tag, rf_rdy, alu_rdy);
            end
            if (!first_seen && (rf_rdy === 1'b1 || alu_rdy === 1'b1)) begin
                first_seen = 1'b1;
                total++;
                if (alu_rdy !== exp_alu_first) begin
                    bad++;
                    $display("[TB] FAIL %s_grant: alu_rdy=%b need %b", tag, alu_rdy, exp_alu_first);
                end
            end
            if (rf_rdy === 1'b1) rf_pend = 1'b0;
            if (alu_rdy === 1'b1) alu_pend = 1'b0;
            @(negedge clk);
            rf_vld = rf_pend;
            alu_vld = alu_pend;
            cyc++;
        end
        total++;
        if (rf_pend || alu_pend) begin
            bad++;
            $display("[TB] FAIL %s_accept_timeout: pending rf=%b alu=%b need 0", tag, rf_pend, alu_pend);
        end
        rf_vld = 1'b0;
        alu_vld = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && c < 200) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        total++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_drain: left=%0d busy=%b need 0/0", tag, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rf_vld = 1'b1;
        alu_vld = 1'b1;
        #12;
        total++;
        if ({rf_rdy, alu_rdy, w_inc, busy} !== 4'b0000 || wr_data !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_outputs: rdy=%b%b w_inc=%b busy=%b wr_data=%h need all 0",
                     rf_rdy, alu_rdy, w_inc, busy, wr_data);
        end
        rf_vld = 1'b0;
        alu_vld = 1'b0;
        apply_reset();
    endtask

    task automatic test_rf_single();
        @(negedge clk);
        rf_vld = 1'b1;
        rf_rd_data = 8'hA5;
        exp_q.push_back(8'hA5);
        model_last = 1'b0;
        #1;
        total++;
        if (rf_rdy !== 1'b1 || alu_rdy !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rf_c0: rf_rdy=%b alu_rdy=%b busy=%b need 1/0/0", rf_rdy, alu_rdy, busy);
        end
        @(negedge clk);
        rf_vld = 1'b0;
        #1;
        total++;
        if (w_inc !== 1'b1 || busy !== 1'b1 || wr_data !== 8'hA5 || rf_rdy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rf_c1: w_inc=%b busy=%b wr_data=%h rf_rdy=%b need 1/1/a5/0", w_inc, busy, wr_data, rf_rdy);
        end
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || w_inc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rf_c2: busy=%b w_inc=%b need 0/0", busy, w_inc);
        end
        wait_idle("rf_single");
    endtask

    task automatic test_alu_single();
        @(negedge clk);
        alu_vld = 1'b1;
        alu_out = 16'h1234;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        model_last = 1'b1;
        #1;
        total++;
        if (alu_rdy !== 1'b1 || rf_rdy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL alu_c0: alu_rdy=%b rf_rdy=%b need 1/0", alu_rdy, rf_rdy);
        end
        @(negedge clk);
        alu_vld = 1'b0;
        #1;
        total++;
        if (w_inc !== 1'b1 || wr_data !== 8'h34) begin
            bad++;
            $display("[TB] FAIL alu_c1: w_inc=%b wr_data=%h need 1/34", w_inc, wr_data);
        end
        @(negedge clk);
        #1;
        total++;
        if (w_inc !== 1'b1 || wr_data !== 8'h12 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL alu_c2: w_inc=%b wr_data=%h busy=%b need 1/12/1", w_inc, wr_data, busy);
        end
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || w_inc !== 1'b0 || wr_data !== 8'h12) begin
            bad++;
            $display("[TB] FAIL alu_c3: busy=%b w_inc=%b wr_data=%h need 0/0/12", busy, w_inc, wr_data);
        end
        wait_idle("alu_single");
    endtask

    // Ties: after reset ALU wins; every later tie goes to whichever source
    // was not granted most recently.
    task automatic test_tie();
        apply_reset();
        drive_req(1'b1, 8'h5A, 1'b1, 16'hBEEF, "tie1");
        wait_idle("tie1");
        drive_req(1'b1, 8'h77, 1'b1, 16'hC0DE, "tie2");
        wait_idle("tie2");
        drive_req(1'b0, 8'h00, 1'b1, 16'h4321, "pre_tie3");
        wait_idle("pre_tie3");
        drive_req(1'b1, 8'h77, 1'b1, 16'hC0DE, "tie3");
        wait_idle("tie3");
    endtask

    task automatic test_full_stall();
        int start_cnt;
        start_cnt = wr_count;
        drive_req(1'b0, 8'h00, 1'b1, 16'hBEEF, "stall");
        @(negedge clk);
        full_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (w_inc !== 1'b0 || wr_data !== 8'hBE || busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL stall_hold%0d: w_inc=%b wr_data=%h busy=%b need 0/be/1", i, w_inc, wr_data, busy);
            end
            @(negedge clk);
        end
        full_force = 1'b0;
        wait_idle("stall");
        total++;
        if (wr_count - start_cnt != 2) begin
            bad++;
            $display("[TB] FAIL stall_count: writes=%0d need 2", wr_count - start_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int start_cnt;
        drive_req(1'b0, 8'h00, 1'b1, 16'hF00D, "rst_mid");
        @(negedge clk);
        void'(exp_q.pop_back());
        rf_vld = 1'b1;
        rf_rd_data = 8'h11;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({rf_rdy, alu_rdy, w_inc, busy} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL rst_mid_outputs: rdy=%b%b w_inc=%b busy=%b need 0000", rf_rdy, alu_rdy, w_inc, busy);
        end
        rf_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL rst_mid_lo: left=%0d need 0", exp_q.size());
        end
        start_cnt = wr_count;
        drive_req(1'b1, 8'h3C, 1'b0, 16'h0000, "after_rst");
        wait_idle("after_rst");
        total++;
        if (wr_count - start_cnt != 1) begin
            bad++;
            $display("[TB] FAIL after_rst_count: writes=%0d need 1", wr_count - start_cnt);
        end
    endtask

    task automatic test_fifo_stream();
        fifo_mem.delete();
        rd_q.delete();
        max_occ = 0;
        @(negedge clk);
        fifo_mode = 1'b1;
        rd_en = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) drive_req(1'b1, 8'(i), 1'b0, 16'h0000, "stream");
            end
            begin
                repeat (40) @(negedge clk);
                rd_en = 1'b1;
            end
        join
        wait_idle("stream");
        repeat (12) @(negedge clk);
        total++;
        if (max_occ != 8) begin
            bad++;
            $display("[TB] FAIL stream_peak: occupancy=%0d need 8", max_occ);
        end
        total++;
        if (rd_q.size() != 10) begin
            bad++;
            $display("[TB] FAIL stream_reads: count=%0d need 10", rd_q.size());
        end
        for (int i = 0; i < 10 && i < rd_q.size(); i++) begin
            total++;
            if (rd_q[i] !== 8'(i)) begin
                bad++;
                $display("[TB] FAIL stream_rd%0d: got %h need %h", i, rd_q[i], 8'(i));
            end
        end
        rd_en = 1'b0;
        fifo_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            logic ur, ua;
            ur = 1'($urandom_range(0, 1));
            ua = 1'($urandom_range(0, 1));
            if (!ur && !ua) ur = 1'b1;
            drive_req(ur, 8'($urandom), ua, 16'($urandom), "b2b");
        end
        wait_idle("b2b");
    endtask

    initial begin
        test_reset();
        test_rf_single();
        test_alu_single();
        test_tie();
        test_full_stall();
        test_reset_mid();
        test_fifo_stream();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
